seq_divider: RTL

//  - Multi-cycle signed integer divider serving the CPU's DIV instruction.
//  - Sits beside the datapath: takes operands from the A/B registers on a
//    one-cycle start pulse from the control unit, and drives the HI/LO

---
 rtl/mdu_pkg.sv | 16 +
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: default operand width,
// counter width and the divider FSM state encoding.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int CNT_W     = $clog2(MDU_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ITER = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    DZ   = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor magnitude if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH:0]   bmag,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The remainder always stays below |b| <= 2^(WIDTH-1), so the difference
  // is exact in WIDTH bits whenever the subtraction is taken.
  always_comb begin
    shifted = {rem, dvd_msb};
    q_bit   = (shifted >= bmag);
    diff    = shifted[WIDTH-1:0] - bmag[WIDTH-1:0];
    rem_nxt = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider (MIPS DIV semantics): lo = quotient truncated
// toward zero, hi = remainder with the sign of the dividend.
module seq_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   bmag_q, bmag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // |INT_MIN| reads correctly as an unsigned WIDTH-bit magnitude.
  always_comb begin
    a_abs = a[WIDTH-1] ? (~a + 1'b1) : a;
    b_ext = {b[WIDTH-1], b};
    b_mag = b[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .dvd_msb (dvd_q[WIDTH-1]),
    .bmag    (bmag_q),
    .rem_nxt (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    bmag_d    = bmag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            state_d = DZ;
            dz_d    = 1'b1;
          end else begin
            state_d   = ITER;
            dz_d      = 1'b0;
            dvd_d     = a_abs;
            bmag_d    = b_mag;
            sgn_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            sgn_rem_d = a[WIDTH-1];
            rem_d     = '0;
            quo_d     = '0;
            cnt_d     = CW'(WIDTH - 1);
          end
        end
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        lo_d    = sgn_quo_q ? -quo_q : quo_q;
        hi_d    = sgn_rem_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      // Divide-by-zero waits one cycle here, then reports through DONE.
      DZ:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      bmag_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      bmag_q    <= bmag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign ready    = (state_q == DONE);
  assign div_zero = (state_q == DONE) && dz_q;
  assign busy     = (state_q != IDLE);

endmodule
